branch_redirect_ctrl: RTL and testbench

//   Sequences branch/jump resolution in decode. Accepts one decoded instr per handshake.

---
 rtl/brj_ctrl_pkg.sv | 34 +++
 rtl/brj_addr_calc.sv | 17 +
 rtl/branch_redirect_ctrl.sv | 127 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/brj_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and branch-decode helpers for the
// branch/jump redirect controller.
package brj_ctrl_pkg;

  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01111;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00110;

  typedef enum logic [1:0] {IDLE, WAIT_RS, REDIR, FLUSH} state_t;

  function automatic logic is_jump(input logic [4:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_BEQZ) || (op == OP_BNEZ) || (op == OP_BLTZ);
  endfunction

  // Condition outcome for a conditional branch; non-branch ops never take.
  function automatic logic br_taken(input logic [4:0] op, input logic [15:0] rs);
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQZ: t = (rs == 16'h0000);
      OP_BNEZ: t = (rs != 16'h0000);
      OP_BLTZ: t = rs[15];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/brj_addr_calc.sv
// Redirect target: pc_inc plus sign-extended imm8 (branch) or imm11 (jump),
// wrapping modulo 2^16.
module brj_addr_calc
  import brj_ctrl_pkg::*;
(
  input  logic [15:0] i_instr,
  input  logic [15:0] i_pc_inc,
  output logic [15:0] o_target
);

  logic [15:0] w_off;

  assign w_off    = is_jump(i_instr[15:11]) ? {{5{i_instr[10]}}, i_instr[10:0]}
                                            : {{8{i_instr[7]}},  i_instr[7:0]};
  assign o_target = i_pc_inc + w_off;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump resolution sequencer between decode and the fetch PC mux.
// Accepts one instr per handshake, resolves the condition (stalling for Rs
// when needed), holds a redirect until fetch acks it, then flushes.
module branch_redirect_ctrl
  import brj_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [15:0]      dec_instr,
  input  logic [15:0]      dec_pc_inc,
  output logic             dec_ready,
  input  logic [15:0]      rs_val,
  input  logic             rs_ready,
  output logic             redirect_valid,
  output logic [15:0]      redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic             link_valid,
  output logic [15:0]      link_val,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_t           r_state;
  logic [15:0]      r_instr;
  logic [15:0]      r_pc_inc;
  logic [FW-1:0]    r_flush_cnt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic             r_link_valid;

  logic             w_accept;
  logic [4:0]       w_dec_op;
  logic [4:0]       w_cap_op;
  logic [15:0]      w_target;

  assign dec_ready = (r_state == IDLE);
  assign w_accept  = dec_valid & dec_ready;
  assign w_dec_op  = dec_instr[15:11];
  assign w_cap_op  = r_instr[15:11];

  // Target is computed from the captured copy so it stays stable in REDIR.
  brj_addr_calc u_addr_calc (
    .i_instr  (r_instr),
    .i_pc_inc (r_pc_inc),
    .o_target (w_target)
  );

  // Capture the accepted instruction; held while the FSM is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_pc_inc <= '0;
    end else if (w_accept) begin
      r_instr  <= dec_instr;
      r_pc_inc <= dec_pc_inc;
    end
  end

  // Control FSM: branches with a ready Rs resolve in the accept cycle,
  // otherwise WAIT_RS re-evaluates the captured opcode against live Rs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (is_jump(w_dec_op)) begin
              r_state <= REDIR;
            end else if (is_branch(w_dec_op)) begin
              if (!rs_ready)                     r_state <= WAIT_RS;
              else if (br_taken(w_dec_op, rs_val)) r_state <= REDIR;
            end
          end
        end
        WAIT_RS: begin
          if (rs_ready) r_state <= br_taken(w_cap_op, rs_val) ? REDIR : IDLE;
        end
        REDIR: begin
          if (redirect_ack) begin
            if (FLUSH_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_state     <= FLUSH;
              r_flush_cnt <= FW'(FLUSH_CYCLES);
            end
          end
        end
        FLUSH: begin
          if (r_flush_cnt <= FW'(1)) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Count acknowledged redirects, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                     r_taken_cnt <= '0;
    else if ((r_state == REDIR) && redirect_ack && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + 1'b1;
  end

  // JAL link write strobe, one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_link_valid <= 1'b0;
    else        r_link_valid <= w_accept && (w_dec_op == OP_JAL);
  end

  assign redirect_valid = (r_state == REDIR);
  assign flush          = (r_state == REDIR) || (r_state == FLUSH);
  assign redirect_pc    = w_target;
  assign link_valid     = r_link_valid;
  assign link_val       = r_pc_inc;
  assign taken_cnt      = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: vector table for single-op
// resolution, hand sequences for Rs stall, ack stall, reset during flush,
// and a second instance (no flush tail, 2-bit counter) for saturation.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0, dec_valid2 = 1'b0;
  logic [15:0] dec_instr = '0, dec_pc_inc = '0, rs_val = '0;
  logic        rs_ready = 1'b0;
  logic        redirect_ack = 1'b0, redirect_ack2 = 1'b0;

  logic        dec_ready, redirect_valid, flush, link_valid;
  logic [15:0] redirect_pc, link_val;
  logic [15:0] taken_cnt;
  logic        dec_ready2, redirect_valid2, flush2, link_valid2;
  logic [15:0] redirect_pc2, link_val2;
  logic [1:0]  taken_cnt2;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_pc_inc(dec_pc_inc), .dec_ready(dec_ready), .rs_val(rs_val),
    .rs_ready(rs_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .flush(flush), .link_valid(link_valid),
    .link_val(link_val), .taken_cnt(taken_cnt)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid2), .dec_instr(dec_instr),
    .dec_pc_inc(dec_pc_inc), .dec_ready(dec_ready2), .rs_val(rs_val),
    .rs_ready(rs_ready), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .redirect_ack(redirect_ack2), .flush(flush2), .link_valid(link_valid2),
    .link_val(link_val2), .taken_cnt(taken_cnt2)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] rs;
    logic        redir;
    logic [15:0] tgt;
    logic        link;
  } vec_t;

  vec_t vecs [11];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Walk the two flush cycles after an ack and land back in IDLE.
  task automatic flush_tail();
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      chk("flush_hold", flush, 1);
      chk("ready_in_flush", dec_ready, 0);
      chk("redir_off_in_flush", redirect_valid, 0);
    end
    @(negedge clk);
    chk("flush_done", flush, 0);
    chk("ready_after_flush", dec_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("ready_pre", dec_ready, 1);
    dec_valid = 1'b1; dec_instr = v.instr; dec_pc_inc = v.pc; rs_val = v.rs; rs_ready = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
    chk("redir_valid", redirect_valid, v.redir);
    chk("link_valid", link_valid, v.link);
    if (v.link) chk("link_val", link_val, v.pc);
    if (v.redir) begin
      chk("redir_pc", redirect_pc, v.tgt);
      chk("flush_in_redir", flush, 1);
      chk("ready_in_redir", dec_ready, 0);
      redirect_ack = 1'b1;
      @(negedge clk);
      redirect_ack = 1'b0;
      exp_cnt++;
      chk("link_pulse_end", link_valid, 0);
      flush_tail();
    end else begin
      chk("ready_no_redir", dec_ready, 1);
      chk("flush_no_redir", flush, 0);
    end
    chk("taken_cnt", taken_cnt, exp_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'h6005, 16'h0100, 16'h0000, 1'b1, 16'h0105, 1'b0}; // BEQZ taken
    vecs[1]  = '{16'h68FE, 16'h0200, 16'h0000, 1'b0, 16'h0000, 1'b0}; // BNEZ not taken
    vecs[2]  = '{16'h68FE, 16'h0200, 16'h0001, 1'b1, 16'h01FE, 1'b0}; // BNEZ taken, back
    vecs[3]  = '{16'h6005, 16'h0100, 16'h0005, 1'b0, 16'h0000, 1'b0}; // BEQZ not taken
    vecs[4]  = '{16'h7810, 16'h1000, 16'h8000, 1'b1, 16'h1010, 1'b0}; // BLTZ taken
    vecs[5]  = '{16'h7810, 16'h1000, 16'h7FFF, 1'b0, 16'h0000, 1'b0}; // BLTZ not taken
    vecs[6]  = '{16'h23FF, 16'h0100, 16'h0000, 1'b1, 16'h04FF, 1'b0}; // J max +imm11
    vecs[7]  = '{16'h3400, 16'h0010, 16'h1234, 1'b1, 16'hFC10, 1'b1}; // JAL min imm11
    vecs[8]  = '{16'h1234, 16'h0100, 16'h0000, 1'b0, 16'h0000, 1'b0}; // non-ctrl op
    vecs[9]  = '{16'h2001, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0}; // J wrap to 0
    vecs[10] = '{16'h6080, 16'h0100, 16'h0000, 1'b1, 16'h0080, 1'b0}; // BEQZ imm8 -128

    // Reset state
    #1;
    chk("rst_ready", dec_ready, 1);
    chk("rst_redir_valid", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_link_valid", link_valid, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_link_val", link_val, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // BLTZ with Rs stalled for 3 cycles; live dec_instr is changed to an op
    // that would not take, so only the captured opcode can redirect.
    @(negedge clk);
    dec_valid = 1'b1; dec_instr = 16'h78FE; dec_pc_inc = 16'h0000; rs_ready = 1'b0; rs_val = 16'h8000;
    @(negedge clk);
    dec_valid = 1'b0; dec_instr = 16'h6000; rs_val = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("wait_ready", dec_ready, 0);
      chk("wait_no_redir", redirect_valid, 0);
      chk("wait_no_flush", flush, 0);
      if (k == 2) begin rs_ready = 1'b1; rs_val = 16'h8000; end
    end
    @(negedge clk);
    chk("wait_redir_valid", redirect_valid, 1);
    chk("wait_redir_pc", redirect_pc, 16'hFFFE);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0; exp_cnt++;
    flush_tail();
    chk("wait_taken_cnt", taken_cnt, exp_cnt);

    // BNEZ stalled on Rs, resolves not-taken back to IDLE.
    dec_valid = 1'b1; dec_instr = 16'h6810; dec_pc_inc = 16'h0040; rs_ready = 1'b0;
    @(negedge clk);
    dec_valid = 1'b0;
    chk("wait_nt_ready", dec_ready, 0);
    rs_ready = 1'b1; rs_val = 16'h0000;
    @(negedge clk);
    chk("wait_nt_idle", dec_ready, 1);
    chk("wait_nt_no_redir", redirect_valid, 0);
    chk("wait_nt_cnt", taken_cnt, exp_cnt);

    // J with ack withheld for 5 REDIR cycles while decode keeps offering.
    @(negedge clk);
    dec_valid = 1'b1; dec_instr = 16'h2010; dec_pc_inc = 16'h0100;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_redir_valid", redirect_valid, 1);
      chk("stall_redir_pc", redirect_pc, 16'h0110);
      chk("stall_ready", dec_ready, 0);
      dec_valid = k[0]; dec_instr = 16'h2400; dec_pc_inc = 16'h5555;
      @(negedge clk);
    end
    chk("stall_pc_before_ack", redirect_pc, 16'h0110);
    dec_valid = 1'b0; redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0; exp_cnt++;
    flush_tail();
    chk("stall_no_extra_redir", redirect_valid, 0);
    chk("stall_taken_cnt", taken_cnt, exp_cnt);

    // Reset asserted during FLUSH.
    dec_valid = 1'b1; dec_instr = 16'h2002; dec_pc_inc = 16'h0300;
    @(negedge clk);
    dec_valid = 1'b0; redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    chk("pre_rst_flush", flush, 1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("midrst_flush", flush, 0);
    chk("midrst_redir_valid", redirect_valid, 0);
    chk("midrst_taken_cnt", taken_cnt, 0);
    chk("midrst_ready", dec_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", dec_ready, 1);
    chk("postrst_flush", flush, 0);

    // Second instance: no flush tail, 2-bit counter saturates at 3.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d2_ready_pre", dec_ready2, 1);
      dec_valid2 = 1'b1; dec_instr = 16'h2004; dec_pc_inc = 16'h0000;
      @(negedge clk);
      dec_valid2 = 1'b0;
      chk("d2_redir_valid", redirect_valid2, 1);
      chk("d2_redir_pc", redirect_pc2, 16'h0004);
      redirect_ack2 = 1'b1;
      @(negedge clk);
      redirect_ack2 = 1'b0;
      exp_cnt2 = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
      chk("d2_flush_zero", flush2, 0);
      chk("d2_ready_at_ack", dec_ready2, 1);
      chk("d2_redir_drop", redirect_valid2, 0);
      chk("d2_taken_cnt", taken_cnt2, exp_cnt2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
